// File: rtl/sr_decode_stage.sv
// rtl/sr_decode_stage.sv - registered RV32I/RV64I decode stage with valid/ready flow control
// Extracts register/opcode fields, builds the immediate for the opcode's format and flags illegal encodings.
module sr_decode_stage #(
  parameter int XLEN = 32,
  parameter int PCW  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PCW-1:0]  in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PCW-1:0]  out_pc,
  output logic [31:0]     out_instr,
  output logic [6:0]      cmdOp,
  output logic [4:0]      rd,
  output logic [2:0]      cmdF3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      cmdF7,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      immFmt,
  output logic            illegal
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic            s;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;
  logic            accept;

  assign s = in_instr[31];

  assign imm_i = {{(XLEN-11){s}}, in_instr[30:20]};
  assign imm_s = {{(XLEN-11){s}}, in_instr[30:25], in_instr[11:7]};
  assign imm_b = {{(XLEN-12){s}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {{(XLEN-31){s}}, in_instr[30:12], 12'b0};
  assign imm_j = {{(XLEN-20){s}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  always_comb begin
    dec_fmt     = FMT_R;
    dec_imm     = '0;
    dec_illegal = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end else begin
      case (in_instr[6:0])
        7'b0110111, 7'b0010111: begin
          dec_fmt = FMT_U;
          dec_imm = imm_u;
        end
        7'b1101111: begin
          dec_fmt = FMT_J;
          dec_imm = imm_j;
        end
        7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: begin
          dec_fmt = FMT_I;
          dec_imm = imm_i;
        end
        7'b0100011: begin
          dec_fmt = FMT_S;
          dec_imm = imm_s;
        end
        7'b1100011: begin
          dec_fmt = FMT_B;
          dec_imm = imm_b;
        end
        7'b0110011: dec_fmt = FMT_R;
        // word-sized OP-IMM-32 / OP-32 only exist on RV64
        7'b0011011: begin
          if (XLEN == 64) begin
            dec_fmt = FMT_I;
            dec_imm = imm_i;
          end else begin
            dec_illegal = 1'b1;
          end
        end
        7'b0111011: begin
          if (XLEN != 64) dec_illegal = 1'b1;
        end
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_instr <= '0;
      cmdOp     <= '0;
      rd        <= '0;
      cmdF3     <= '0;
      rs1       <= '0;
      rs2       <= '0;
      cmdF7     <= '0;
      imm       <= '0;
      immFmt    <= '0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_pc    <= in_pc;
      out_instr <= in_instr;
      cmdOp     <= in_instr[6:0];
      rd        <= in_instr[11:7];
      cmdF3     <= in_instr[14:12];
      rs1       <= in_instr[19:15];
      rs2       <= in_instr[24:20];
      cmdF7     <= in_instr[31:25];
      imm       <= dec_imm;
      immFmt    <= dec_fmt;
      illegal   <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
